mem_access_unit: RTL and testbench

- Memory-access stage between execute and the MEM/WB pipeline register.
- Takes the execute-stage address and store data, runs one data-memory transaction over a req/ack bus, and produces the aligned, sign- or zero-extended load word.
- Its load-word output drives the MEM/WB register's wrap_load_in.
- Stalls the pipeline while a transaction is outstanding.

---
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-access stage: one req/ack data-memory transaction per load/store, with lane steering and load extension.
// Optional MEM_TIMEOUT_EN aborts a transfer after TIMEOUT_CYCLES unacknowledged REQ cycles.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_out,
    output logic [31:0] wrap_load_out,
    output logic        mem_done_out,
    output logic        misalign_out,
    output logic        bus_err_out
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      r_state;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;

    logic        w_isLoad;
    logic        w_isStore;
    logic        w_access;
    logic        w_legal;
    logic        w_aligned;
    logic        w_start;
    logic        w_bad;
    logic        w_timeout;
    logic [1:0]  w_off;
    logic [3:0]  w_wmask;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_loadExt;

    // A load wins when both load and store are flagged.
    assign w_isLoad  = ex_load;
    assign w_isStore = ex_store & ~ex_load;
    assign w_off     = ex_addr[1:0];
    assign w_access  = ex_valid & (ex_load | ex_store);
    assign w_start   = w_access & w_legal & w_aligned;
    assign w_bad     = w_access & ~(w_legal & w_aligned);
    assign stall_out = (r_state == REQ) | ((r_state == IDLE) & w_start);

    always_comb begin
        w_legal   = 1'b0;
        w_aligned = 1'b0;
        if (w_isLoad)
            w_legal = ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else
            w_legal = ex_funct3 inside {3'b000, 3'b001, 3'b010};
        case (ex_funct3[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~w_off[0];
            2'b10:   w_aligned = (w_off == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    always_comb begin
        w_wmask = 4'b0000;
        w_wdata = ex_store_data;
        case (ex_funct3[1:0])
            2'b00: begin
                w_wmask = 4'b0001 << w_off;
                w_wdata = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                w_wmask = 4'b0011 << {w_off[1], 1'b0};
                w_wdata = {2{ex_store_data[15:0]}};
            end
            default: begin
                w_wmask = 4'b1111;
                w_wdata = ex_store_data;
            end
        endcase
    end

    always_comb begin
        w_byte    = dmem_rdata[{r_off, 3'b000} +: 8];
        w_half    = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        w_loadExt = dmem_rdata;
        case (r_funct3)
            3'b000:  w_loadExt = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_loadExt = {24'd0, w_byte};
            3'b001:  w_loadExt = {{16{w_half[15]}}, w_half};
            3'b101:  w_loadExt = {16'd0, w_half};
            default: w_loadExt = dmem_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_tmoCnt;

    // An ack in the same cycle as the limit takes priority over the abort.
    assign w_timeout = (r_state == REQ) & ~dmem_ack & (r_tmoCnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmoCnt    <= '0;
            bus_err_out <= 1'b0;
        end else begin
            bus_err_out <= w_timeout;
            if (r_state == IDLE)
                r_tmoCnt <= '0;
            else if ((r_state == REQ) && !dmem_ack)
                r_tmoCnt <= r_tmoCnt + 1'b1;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign bus_err_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_funct3      <= 3'd0;
            r_off         <= 2'd0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 32'd0;
            dmem_wdata    <= 32'd0;
            dmem_wmask    <= 4'd0;
            wrap_load_out <= 32'd0;
            mem_done_out  <= 1'b0;
            misalign_out  <= 1'b0;
        end else begin
            mem_done_out <= 1'b0;
            misalign_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state    <= REQ;
                        r_funct3   <= ex_funct3;
                        r_off      <= w_off;
                        dmem_req   <= 1'b1;
                        dmem_we    <= w_isStore;
                        dmem_addr  <= {ex_addr[31:2], 2'b00};
                        dmem_wdata <= w_isStore ? w_wdata : 32'd0;
                        dmem_wmask <= w_isStore ? w_wmask : 4'd0;
                    end else if (w_bad) begin
                        misalign_out  <= 1'b1;
                        wrap_load_out <= 32'd0;
                    end
                end
                REQ: begin
                    if (dmem_ack || w_timeout) begin
                        r_state       <= DONE;
                        dmem_req      <= 1'b0;
                        dmem_we       <= 1'b0;
                        dmem_wmask    <= 4'd0;
                        mem_done_out  <= 1'b1;
                        wrap_load_out <= (dmem_ack && !dmem_we) ? w_loadExt : 32'd0;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan cases, reset-in-REQ, randomized accesses against a byte-level reference model.
// Timeout cases are exercised only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_load;
    logic        ex_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall_out;
    logic [31:0] wrap_load_out;
    logic        mem_done_out;
    logic        misalign_out;
    logic        bus_err_out;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [31:0] modelLoad   = 32'd0;
    int          stallCycles;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_out(stall_out), .wrap_load_out(wrap_load_out),
        .mem_done_out(mem_done_out), .misalign_out(misalign_out),
        .bus_err_out(bus_err_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Reference model: access size in bytes, legality, and byte-wise lane behaviour.
    function automatic int accessSize(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit modelLegal(input bit ld, input logic [2:0] f3, input logic [1:0] off);
        if (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b0;
        if (!ld && f3 > 3'd2) return 1'b0;
        return (int'(off) % accessSize(f3)) == 0;
    endfunction

    function automatic logic [31:0] modelLoadValue(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rdata);
        int          size = accessSize(f3);
        logic [31:0] lowMask;
        logic [31:0] v;
        if (size == 4) return rdata;
        lowMask = (32'd1 << (8 * size)) - 32'd1;
        v = (rdata >> (8 * int'(off))) & lowMask;
        if (!f3[2] && ((v >> (8 * size - 1)) & 32'd1) == 32'd1) v = v | ~lowMask;
        return v;
    endfunction

    function automatic logic [3:0] modelMask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m = 4'd0;
        for (int k = 0; k < 4; k++)
            m[k] = (k >= int'(off)) && (k < int'(off) + accessSize(f3));
        return m;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] sdata);
        logic [31:0] w = 32'd0;
        int          size = accessSize(f3);
        for (int k = 0; k < 4; k++)
            w[8*k +: 8] = sdata[8*(k % size) +: 8];
        return w;
    endfunction

    // Presents one instruction at a negedge and follows it until the unit is back in IDLE.
    task automatic applyStimulus(input bit ld, input bit st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] rdata, input int ackDelay);
        bit isLoad = ld;
        bit legal  = modelLegal(isLoad, f3, addr[1:0]);
        stallCycles   = 0;
        ex_valid      = 1'b1;
        ex_load       = ld;
        ex_store      = st;
        ex_funct3     = f3;
        ex_addr       = addr;
        ex_store_data = sdata;
        #1;
        if (!(ld || st)) begin
            checkOutput("nonmem_stall", {31'd0, stall_out}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            checkOutput("nonmem_req", {31'd0, dmem_req}, 32'd0);
            checkOutput("nonmem_load_held", wrap_load_out, modelLoad);
            ex_valid = 1'b0;
            return;
        end
        if (!legal) begin
            checkOutput("bad_stall", {31'd0, stall_out}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            modelLoad = 32'd0;
            checkOutput("bad_misalign", {31'd0, misalign_out}, 32'd1);
            checkOutput("bad_req", {31'd0, dmem_req}, 32'd0);
            checkOutput("bad_load_zero", wrap_load_out, modelLoad);
            ex_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            checkOutput("bad_pulse_end", {31'd0, misalign_out}, 32'd0);
            return;
        end
        checkOutput("start_stall", {31'd0, stall_out}, 32'd1);
        checkOutput("start_req", {31'd0, dmem_req}, 32'd0);
        stallCycles++;
        @(posedge clk);
        for (int c = 0; c <= ackDelay; c++) begin
            @(negedge clk);
            checkOutput("req_high", {31'd0, dmem_req}, 32'd1);
            if (stall_out) stallCycles++;
            if (c == 0) begin
                checkOutput("req_addr", dmem_addr, {addr[31:2], 2'b00});
                checkOutput("req_we", {31'd0, dmem_we}, {31'd0, !isLoad});
                checkOutput("req_wmask", {28'd0, dmem_wmask}, isLoad ? 32'd0 : {28'd0, modelMask(f3, addr[1:0])});
                if (!isLoad) checkOutput("req_wdata", dmem_wdata, modelWdata(f3, sdata));
            end
            if (c == ackDelay) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            @(posedge clk);
        end
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        modelLoad  = isLoad ? modelLoadValue(f3, addr[1:0], rdata) : 32'd0;
        checkOutput("done_pulse", {31'd0, mem_done_out}, 32'd1);
        checkOutput("done_stall", {31'd0, stall_out}, 32'd0);
        checkOutput("done_req", {31'd0, dmem_req}, 32'd0);
        checkOutput("done_load", wrap_load_out, modelLoad);
        checkOutput("done_bus_err", {31'd0, bus_err_out}, 32'd0);
        checkOutput("stall_cycles", stallCycles, ackDelay + 2);
        ex_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("idle_done_low", {31'd0, mem_done_out}, 32'd0);
        checkOutput("idle_load_held", wrap_load_out, modelLoad);
    endtask

    initial begin
        rst           = 1'b0;
        ex_valid      = 1'b0;
        ex_load       = 1'b0;
        ex_store      = 1'b0;
        ex_funct3     = 3'd0;
        ex_addr       = 32'd0;
        ex_store_data = 32'd0;
        dmem_rdata    = 32'd0;
        dmem_ack      = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_req", {31'd0, dmem_req}, 32'd0);
        checkOutput("rst_stall", {31'd0, stall_out}, 32'd0);
        checkOutput("rst_wmask", {28'd0, dmem_wmask}, 32'd0);
        checkOutput("rst_addr", dmem_addr, 32'd0);
        checkOutput("rst_load", wrap_load_out, 32'd0);
        checkOutput("rst_flags", {29'd0, mem_done_out, misalign_out, bus_err_out}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] directed plan cases");
        applyStimulus(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        checkOutput("LW_plan", wrap_load_out, 32'hDEADBEEF);
        applyStimulus(1, 0, 3'b000, 32'h203, 32'h0, 32'h80112233, 1);
        checkOutput("LB_plan", wrap_load_out, 32'hFFFFFF80);
        applyStimulus(1, 0, 3'b100, 32'h203, 32'h0, 32'h80112233, 0);
        checkOutput("LBU_plan", wrap_load_out, 32'h00000080);
        applyStimulus(1, 0, 3'b101, 32'h202, 32'h0, 32'h80112233, 2);
        checkOutput("LHU_plan", wrap_load_out, 32'h00008011);
        applyStimulus(0, 1, 3'b000, 32'h301, 32'h000000A5, 32'h0, 0);
        applyStimulus(0, 1, 3'b001, 32'h302, 32'h0000BEEF, 32'h0, 1);
        applyStimulus(1, 0, 3'b010, 32'h100, 32'h0, 32'h12345678, 0);
        applyStimulus(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
        applyStimulus(0, 1, 3'b001, 32'h101, 32'h1234, 32'h0, 0);
        applyStimulus(1, 1, 3'b011, 32'h100, 32'h0, 32'h0, 0);
        applyStimulus(1, 1, 3'b001, 32'h106, 32'h0, 32'hCAFEF00D, 0);
        checkOutput("LOAD_wins", wrap_load_out, 32'hFFFFCAFE);

        $display("[TB] reset during REQ");
        ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0;
        ex_funct3 = 3'b010; ex_addr = 32'h400;
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            @(posedge clk);
        end
        @(negedge clk);
        checkOutput("rstreq_before", {31'd0, dmem_req}, 32'd1);
        rst = 1'b0;
        ex_valid = 1'b0;
        #1;
        modelLoad = 32'd0;
        checkOutput("rstreq_req", {31'd0, dmem_req}, 32'd0);
        checkOutput("rstreq_stall", {31'd0, stall_out}, 32'd0);
        checkOutput("rstreq_addr", dmem_addr, 32'd0);
        checkOutput("rstreq_load", wrap_load_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h55AA55AA;
        @(negedge clk);
        dmem_ack = 1'b0;
        checkOutput("late_ack_done", {31'd0, mem_done_out}, 32'd0);
        checkOutput("late_ack_load", wrap_load_out, 32'd0);
        checkOutput("late_ack_req", {31'd0, dmem_req}, 32'd0);
        applyStimulus(1, 0, 3'b010, 32'h404, 32'h0, 32'h0BADF00D, 1);
        checkOutput("post_rst_LW", wrap_load_out, 32'h0BADF00D);

`ifdef MEM_TIMEOUT_EN
        $display("[TB] timeout cases");
        begin
            int reqCycles = 0;
            ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0;
            ex_funct3 = 3'b010; ex_addr = 32'h500;
            @(posedge clk);
            repeat (10) begin
                @(negedge clk);
                if (!dmem_req) break;
                reqCycles++;
                @(posedge clk);
            end
            modelLoad = 32'd0;
            checkOutput("tmo_req_cycles", reqCycles, 4);
            checkOutput("tmo_bus_err", {31'd0, bus_err_out}, 32'd1);
            checkOutput("tmo_done", {31'd0, mem_done_out}, 32'd1);
            checkOutput("tmo_load", wrap_load_out, 32'd0);
            ex_valid = 1'b0;
            @(negedge clk);
            checkOutput("tmo_pulse_end", {31'd0, bus_err_out}, 32'd0);
        end
        applyStimulus(1, 0, 3'b010, 32'h504, 32'h0, 32'h13579BDF, 3);
        checkOutput("tmo_ack_wins", wrap_load_out, 32'h13579BDF);
`endif

        $display("[TB] randomized accesses");
        for (int i = 0; i < 60; i++) begin
            int          kind  = $urandom_range(0, 9);
            bit          ld    = $urandom_range(0, 1) == 1;
            bit          st    = $urandom_range(0, 1) == 1;
            logic [2:0]  f3    = 3'($urandom_range(0, 7));
            logic [31:0] addr  = $urandom;
            logic [31:0] sdata = $urandom;
            logic [31:0] rdata = $urandom;
            if (kind == 0) begin
                ld = 1'b0;
                st = 1'b0;
            end else if (!ld && !st) begin
                ld = 1'b1;
            end
            if (kind >= 6) addr[1:0] = 2'b00;
            applyStimulus(ld, st, f3, addr, sdata, rdata, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
